// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank responder with byte strobes.
// Exports register contents and per-register write pulses.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [2:0]                     awprot,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [2:0]                     arprot,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int SW   = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(SW);
  localparam int XW   = ADDR_WIDTH - OFFS;
  localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, wready_q, arready_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_fire, w_fire, ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [SW-1:0]         c_strb;
  logic [XW-1:0]         w_idx, r_idx;
  logic                  w_ok, r_ok;
  logic                  unused_bits;

  assign aw_fire = awvalid & awready_q;
  assign w_fire  = wvalid & wready_q;
  assign ar_fire = arvalid & arready_q;

  // A beat transferring this edge bypasses its holding register
  assign c_addr = aw_fire ? awaddr : awaddr_q;
  assign c_data = w_fire ? wdata : wdata_q;
  assign c_strb = w_fire ? wstrb : wstrb_q;

  assign w_idx = c_addr[ADDR_WIDTH-1:OFFS];
  assign r_idx = araddr[ADDR_WIDTH-1:OFFS];
  assign w_ok  = (w_idx < XW'(NUM_REGS));
  assign r_ok  = (r_idx < XW'(NUM_REGS));

  assign unused_bits = ^{awprot, arprot,
                         c_addr[OFFS-1:0],
                         araddr[OFFS-1:0]};

  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    wr_pulse_d = '0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
          bresp_d   = w_ok ? OKAY : SLVERR;
          if (w_ok) wr_pulse_d[w_idx[IW-1:0]] = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      awready_q  <= (w_state_d == W_IDLE) & ~aw_held_d;
      wready_q   <= (w_state_d == W_IDLE) & ~w_held_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (commit && w_ok) begin
      for (int b = 0; b < SW; b++)
        if (c_strb[b])
          regs_q[w_idx[IW-1:0]][8*b +: 8] <= c_data[8*b +: 8];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_RESP;
          rdata_d   = r_ok ? regs_q[r_idx[IW-1:0]] : '0;
          rresp_d   = r_ok ? OKAY : SLVERR;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= (r_state_d == R_IDLE);
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = (w_state_q == W_RESP);
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = (r_state_q == R_RESP);
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule
